// File: rtl/loop_seq_param_if.sv
// Bus bundle for the loop sequencer: control inputs from the core, program counter and status back.
// No valid/ready handshake here: every input is sampled on each rising clk edge while en is high (clr_err regardless of en).
interface loop_seq_param_if #(
  parameter int AW = 16,
  parameter int IW = 8,
  parameter int SW = 8,
  parameter int DW = 3
);
  logic          en;
  logic          loop_we;
  logic [IW-1:0] loop_iter;
  logic [SW-1:0] loop_size;
  logic          jmp;
  logic [AW-1:0] jmp_addr;
  logic          clr_err;
  logic [AW-1:0] addr;
  logic [DW-1:0] depth;
  logic          in_loop;
  logic          err_ovf;

  modport master (
    output en, loop_we, loop_iter, loop_size, jmp, jmp_addr, clr_err,
    input  addr, depth, in_loop, err_ovf
  );

  modport slave (
    input  en, loop_we, loop_iter, loop_size, jmp, jmp_addr, clr_err,
    output addr, depth, in_loop, err_ovf
  );
endinterface

// File: rtl/loop_seq_param.sv
// Zero-overhead program sequencer with a DEPTH-entry hardware loop stack and computed jumps.
// Loop ends that share an address with enclosing loops resolve in a single cycle.
module loop_seq_param #(
  parameter int AW    = 16,
  parameter int IW    = 8,
  parameter int SW    = 8,
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  loop_seq_param_if.slave bus
);

  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_sp;
  logic             r_err;
  logic [AW-1:0]    r_start [DEPTH];
  logic [AW-1:0]    r_end   [DEPTH];
  logic [IW-1:0]    r_cnt   [DEPTH];

  logic [AW-1:0]    w_size_ext;
  logic [DW-1:0]    w_pop_sp;
  logic             w_hit;
  logic             w_stop;
  logic [AW-1:0]    w_hit_start;
  logic [DEPTH-1:0] w_dec;
  logic [AW-1:0]    w_next_addr;
  logic [DW-1:0]    w_next_sp;
  logic             w_push;
  logic             w_ovf;
  logic             w_dec_en;

  assign w_size_ext = AW'(bus.loop_size);

  // Top-down scan: pop exhausted entries ending here, re-enter the first live one.
  always_comb begin
    w_pop_sp    = r_sp;
    w_hit       = 1'b0;
    w_stop      = 1'b0;
    w_hit_start = '0;
    w_dec       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!w_stop && (i < int'(r_sp))) begin
        if (r_end[i] != r_addr) begin
          w_stop = 1'b1;
        end else if (r_cnt[i] == '0) begin
          w_pop_sp = DW'(i);
        end else begin
          w_hit       = 1'b1;
          w_hit_start = r_start[i];
          w_dec[i]    = 1'b1;
          w_stop      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next_addr = r_addr + AW'(1);
    w_next_sp   = r_sp;
    w_push      = 1'b0;
    w_ovf       = 1'b0;
    w_dec_en    = 1'b0;
    if (bus.jmp) begin
      w_next_addr = bus.jmp_addr;
      w_next_sp   = '0;
    end else if (bus.loop_we) begin
      if (bus.loop_iter == '0) begin
        w_next_addr = r_addr + w_size_ext + AW'(1);
      end else if (bus.loop_size == '0) begin
        w_next_addr = r_addr + AW'(1);
      end else if (r_sp < DW'(DEPTH)) begin
        w_push    = 1'b1;
        w_next_sp = r_sp + DW'(1);
      end else begin
        w_ovf = 1'b1;
      end
    end else begin
      w_next_sp = w_pop_sp;
      if (w_hit) begin
        w_next_addr = w_hit_start;
        w_dec_en    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_sp   <= '0;
    end else if (bus.en) begin
      r_addr <= w_next_addr;
      r_sp   <= w_next_sp;
    end
  end

  // Overflow set beats a simultaneous clear; clear is honoured even while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (bus.en && w_ovf) begin
      r_err <= 1'b1;
    end else if (bus.clr_err) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (DW'(i) == r_sp)) begin
          r_start[i] <= r_addr + AW'(1);
          r_end[i]   <= r_addr + w_size_ext;
          r_cnt[i]   <= bus.loop_iter - IW'(1);
        end else if (w_dec_en && w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] - IW'(1);
        end
      end
    end
  end

  assign bus.addr    = r_addr;
  assign bus.depth   = r_sp;
  assign bus.in_loop = (r_sp != '0);
  assign bus.err_ovf = r_err;

endmodule

// File: tb/tb_loop_seq_param.sv
// Bench for loop_seq_param: directed program scenarios plus a random phase, all checked against a stack model.
module tb_loop_seq_param;
  localparam int AW    = 8;
  localparam int IW    = 4;
  localparam int SW    = 4;
  localparam int DEPTH = 2;
  localparam int DW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [AW-1:0] s;
    logic [AW-1:0] e;
    logic [IW-1:0] c;
  } ent_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  loop_seq_param_if #(.AW(AW), .IW(IW), .SW(SW), .DW(DW)) bus();

  loop_seq_param #(.AW(AW), .IW(IW), .SW(SW), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // program memory seen by the sequencer
  logic          prog_we [256];
  logic [IW-1:0] prog_n  [256];
  logic [SW-1:0] prog_s  [256];

  // reference model
  logic [AW-1:0] m_addr;
  logic          m_err;
  ent_t          stk[$];
  logic [AW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      prog_we[i] = 1'b0;
      prog_n[i]  = '0;
      prog_s[i]  = '0;
    end
  endtask

  task automatic model_reset();
    m_addr = '0;
    m_err  = 1'b0;
    stk.delete();
  endtask

  task automatic model_step(input logic en, input logic we, input logic [IW-1:0] n,
                            input logic [SW-1:0] s, input logic j, input logic [AW-1:0] ja,
                            input logic clr);
    logic          ovf;
    logic [AW-1:0] p;
    ent_t          e;
    int            top;
    ovf = 1'b0;
    if (en) begin
      if (j) begin
        m_addr = ja;
        stk.delete();
      end else if (we) begin
        if (n == 0) m_addr = AW'(m_addr + s + 1);
        else if (s == 0) m_addr = AW'(m_addr + 1);
        else if (stk.size() < DEPTH) begin
          e.s = AW'(m_addr + 1);
          e.e = AW'(m_addr + s);
          e.c = IW'(n - 1);
          stk.push_back(e);
          m_addr = AW'(m_addr + 1);
        end else begin
          ovf = 1'b1;
          m_addr = AW'(m_addr + 1);
        end
      end else begin
        p = m_addr;
        while (stk.size() > 0 && stk[stk.size()-1].e == p && stk[stk.size()-1].c == 0)
          void'(stk.pop_back());
        top = stk.size() - 1;
        if (top >= 0 && stk[top].e == p) begin
          stk[top].c = IW'(stk[top].c - 1);
          m_addr = stk[top].s;
        end else begin
          m_addr = AW'(p + 1);
        end
      end
    end
    if (en && ovf) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    exp_q.push_back(m_addr);
  endtask

  // driver: one clock cycle; loop_we comes from the program at the model's pc
  task automatic run_cycle(input logic en, input logic j, input logic [AW-1:0] ja,
                           input logic clr, input logic we_force);
    logic [AW-1:0] exp_addr;
    bus.en        = en;
    bus.loop_we   = we_force | prog_we[m_addr];
    bus.loop_iter = prog_n[m_addr];
    bus.loop_size = prog_s[m_addr];
    bus.jmp       = j;
    bus.jmp_addr  = ja;
    bus.clr_err   = clr;
    model_step(en, bus.loop_we, bus.loop_iter, bus.loop_size, j, ja, clr);
    @(posedge clk);
    #1;
    exp_addr = exp_q.pop_front();
    check("addr", 32'(bus.addr), 32'(exp_addr));
    check("depth", 32'(bus.depth), 32'(stk.size()));
    check("in_loop", 32'(bus.in_loop), 32'(stk.size() != 0));
    check("err_ovf", 32'(bus.err_ovf), 32'(m_err));
  endtask

  task automatic step();
    run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input logic [AW-1:0] target, input int budget);
    int k;
    k = 0;
    while (m_addr != target && k < budget) begin
      step();
      k++;
    end
    if (m_addr != target) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_to_timeout got=%0h exp=%0h", m_addr, target);
    end
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.loop_we = 1'b0; bus.loop_iter = '0; bus.loop_size = '0;
    bus.jmp = 1'b0; bus.jmp_addr = '0; bus.clr_err = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  int t2[7]  = '{3, 4, 3, 4, 3, 4, 5};
  int t3[15] = '{1, 2, 3, 4, 2, 3, 4, 1, 2, 3, 4, 2, 3, 4, 5};

  initial begin
    logic [AW-1:0] held;
    int max_d;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    clear_prog();
    model_reset();

    // 1: reset state, free run, wrap
    do_reset();
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_depth", 32'(bus.depth), 32'd0);
    check("rst_in_loop", 32'(bus.in_loop), 32'd0);
    check("rst_err", 32'(bus.err_ovf), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("free_run_5", 32'(bus.addr), 32'd5);
    run_cycle(1'b1, 1'b1, 8'hFD, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("wrap", 32'(bus.addr), 32'd1);

    // 2: single loop N=3 S=2 at addr 2
    do_reset();
    clear_prog();
    prog_we[2] = 1'b1; prog_n[2] = 4'd3; prog_s[2] = 4'd2;
    step(); step();
    for (int i = 0; i < 7; i++) begin
      step();
      check("t2_seq", 32'(bus.addr), 32'(t2[i]));
    end
    check("t2_depth_end", 32'(bus.depth), 32'd0);

    // 3: nested loops sharing end address 4
    do_reset();
    clear_prog();
    prog_we[0] = 1'b1; prog_n[0] = 4'd2; prog_s[0] = 4'd4;
    prog_we[1] = 1'b1; prog_n[1] = 4'd2; prog_s[1] = 4'd3;
    max_d = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      check("t3_seq", 32'(bus.addr), 32'(t3[i]));
      if (int'(bus.depth) > max_d) max_d = int'(bus.depth);
    end
    check("t3_max_depth", 32'(max_d), 32'd2);
    check("t3_depth_end", 32'(bus.depth), 32'd0);

    // 4: zero-iteration skip, overflow, clear
    do_reset();
    clear_prog();
    prog_we[5] = 1'b1; prog_n[5] = 4'd0; prog_s[5] = 4'd3;
    run_to(8'd5, 20);
    step();
    check("t4_skip_addr", 32'(bus.addr), 32'd9);
    check("t4_skip_depth", 32'(bus.depth), 32'd0);
    prog_we[10] = 1'b1; prog_n[10] = 4'd2; prog_s[10] = 4'd6;
    prog_we[11] = 1'b1; prog_n[11] = 4'd2; prog_s[11] = 4'd4;
    prog_we[12] = 1'b1; prog_n[12] = 4'd2; prog_s[12] = 4'd2;
    run_to(8'd12, 20);
    step();
    check("t4_ovf_err", 32'(bus.err_ovf), 32'd1);
    check("t4_ovf_depth", 32'(bus.depth), 32'd2);
    check("t4_ovf_addr", 32'(bus.addr), 32'd13);
    run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("t4_clr", 32'(bus.err_ovf), 32'd0);
    for (int i = 0; i < 30; i++) step();

    // 5: stall mid-loop, then jmp with loop_we ignored
    do_reset();
    clear_prog();
    prog_we[8'h20] = 1'b1; prog_n[8'h20] = 4'd3; prog_s[8'h20] = 4'd8;
    prog_we[8'h21] = 1'b1; prog_n[8'h21] = 4'd3; prog_s[8'h21] = 4'd4;
    run_cycle(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    held = m_addr;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("t5_hold", 32'(bus.addr), 32'(held));
    end
    step();
    check("t5_depth2", 32'(bus.depth), 32'd2);
    run_cycle(1'b1, 1'b1, 8'h40, 1'b0, 1'b1);
    check("t5_jmp_addr", 32'(bus.addr), 32'h40);
    check("t5_jmp_depth", 32'(bus.depth), 32'd0);

    // 6: async reset between edges at depth 2
    run_cycle(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check("t6_pre_depth", 32'(bus.depth), 32'd2);
    #3 reset = 1'b1;
    #1;
    check("t6_async_addr", 32'(bus.addr), 32'd0);
    check("t6_async_depth", 32'(bus.depth), 32'd0);
    #2 reset = 1'b0;
    model_reset();
    exp_q.delete();
    for (int i = 0; i < 6; i++) step();

    // random programs and control
    for (int r = 0; r < 4; r++) begin
      do_reset();
      clear_prog();
      for (int a = 0; a < 256; a++) begin
        if ($urandom_range(0, 9) == 0) begin
          prog_we[a] = 1'b1;
          prog_n[a]  = IW'($urandom_range(0, 3));
          prog_s[a]  = SW'($urandom_range(0, 6));
        end
      end
      for (int c = 0; c < 400; c++) begin
        run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                  AW'($urandom_range(0, 255)), $urandom_range(0, 15) == 0, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
